// File: rtl/if_pkg.sv
// Shared fetch-stage definitions: controller state encoding and the boot address
// that both the pc register and the benches start from.
package if_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    DATA    = 3'd2,
    DISCARD = 3'd3,
    HOLD    = 3'd4
  } fetch_state_e;

  localparam logic [31:0] RESET_VECTOR = 32'hbfc00000;

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// SRAM-like instruction-memory port: one request/address phase and one data phase,
// with at most one transaction outstanding.
interface if_fetch_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [DATA_W-1:0] inst_rdata;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_data_ok,
    input  inst_rdata
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok,
    output inst_data_ok,
    output inst_rdata
  );

endinterface

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: sequences one memory read per instruction, buffers
// the word for decode, stalls pc until it is consumed, and drops stale responses.
module if_fetch_ctrl
  import if_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic              redirect,
  input  logic              pipe_stall,
  if_fetch_ctrl_if.master   mem,
  output logic              fetch_stall,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_inst,
  output logic [ADDR_W-1:0] if_pc
);

  fetch_state_e      r_state;
  fetch_state_e      w_next_state;
  logic [DATA_W-1:0] r_inst_q;
  logic [ADDR_W-1:0] r_pc_q;
  logic              w_inst_req;
  logic              w_capture;
  logic              w_latch_pc;

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_inst_req   = 1'b0;
    w_capture    = 1'b0;
    w_latch_pc   = 1'b0;
    case (r_state)
      IDLE: w_next_state = ADDR;
      ADDR: begin
        // A redirect cycle must never carry the pre-redirect address onto the bus.
        w_inst_req = ~redirect;
        if (w_inst_req && mem.inst_addr_ok) begin
          w_latch_pc   = 1'b1;
          w_next_state = DATA;
        end
      end
      DATA: begin
        if (mem.inst_data_ok) begin
          if (!redirect) begin
            w_capture    = 1'b1;
            w_next_state = HOLD;
          end else begin
            w_next_state = ADDR;
          end
        end else if (redirect) begin
          w_next_state = DISCARD;
        end
      end
      DISCARD: begin
        if (mem.inst_data_ok) w_next_state = ADDR;
      end
      HOLD: begin
        if (!pipe_stall || redirect) w_next_state = ADDR;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_inst_q <= '0;
      r_pc_q   <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_capture)  r_inst_q <= mem.inst_rdata;
      if (w_latch_pc) r_pc_q   <= pc_addr;
    end
  end

  assign mem.inst_req  = w_inst_req;
  assign mem.inst_addr = pc_addr;

  // pc may move only when the buffered word is consumed or a redirect reloads it.
  assign fetch_stall = ~(redirect | ((r_state == HOLD) & ~pipe_stall));
  assign if_valid    = (r_state == HOLD) & ~redirect;
  assign if_inst     = r_inst_q;
  assign if_pc       = r_pc_q;

endmodule

// File: doc/if_fetch_ctrl.md
# if_fetch_ctrl

Instruction-fetch controller placed between the `pc` register and the instruction-memory port (sram-like handshake: `req`/`addr_ok`/`data_ok`). It owns the fetch sequence:

- issues the address held by `pc`;
- waits for the address and data handshakes;
- buffers the returned word until the decode stage accepts it;
- stalls `pc` until that acceptance;
- discards in-flight responses when a branch or exception redirects fetch.

## Interface
Parameters:
- `ADDR_W`, 32, width of PC and instruction bus address.
- `DATA_W`, 32, instruction word width.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-low reset (reset applied when `rst`==0 at a rising edge).
- `pc_addr`  in  ADDR_W  current fetch address from `pc`.
- `redirect`  in  1  branch taken or exception this cycle; current fetch is stale.
- `pipe_stall`  in  1  decode stage cannot accept an instruction this cycle.
- `inst_req`  out  1  instruction-memory request valid.
- `inst_addr`  out  ADDR_W  request address.
- `inst_addr_ok`  in  1  memory accepted the address this cycle.
- `inst_data_ok`  in  1  read data valid this cycle.
- `inst_rdata`  in  DATA_W  read data.
- `fetch_stall`  out  1  to `pc.stall`; holds `pc` while fetch is incomplete.
- `if_valid`  out  1  `if_inst`/`if_pc` hold a valid instruction.
- `if_inst`  out  DATA_W  buffered instruction.
- `if_pc`  out  ADDR_W  address of `if_inst`.

## Operation
States:
- **IDLE**, reset state.
  - → ADDR unconditionally on the next edge.
- **ADDR**
  - Outputs: `inst_req` = ~`redirect`; `inst_addr` = `pc_addr` (combinational).
  - On `inst_req & inst_addr_ok`: latch `inst_addr` into `pc_q`, → DATA.
  - On `redirect` without handshake: stay in ADDR; the request is re-issued next cycle at the new `pc_addr`.
- **DATA**, waiting for read data.
  - `data_ok & ~redirect`: latch `inst_rdata`→`inst_q`, → HOLD.
  - `data_ok & redirect`: drop the data, → ADDR.
  - `~data_ok & redirect`: → DISCARD.
- **DISCARD**, draining a stale response.
  - On `data_ok`: drop the data, → ADDR.
  - A further `redirect` here has no effect on state.
- **HOLD**
  - `if_valid`=1.
  - `~pipe_stall | redirect`: → ADDR.

`fetch_stall` is 1 in every cycle except:
- HOLD with `~pipe_stall` (instruction consumed; `pc` advances);
- any cycle with `redirect`=1 (`pc` loads the branch target).

`if_inst`=`inst_q` and `if_pc`=`pc_q` are registered. `if_valid` = (state==HOLD) & ~`redirect`.

Reset values:
- state IDLE;
- `inst_req`=0, `if_valid`=0, `fetch_stall`=1;
- `inst_q`=0, `pc_q`=0.

Reset mid-transaction abandons any outstanding request. The memory side is reset concurrently, so no drain is required.

## Timing
- Minimum 3 cycles per instruction: ADDR(1) + DATA(1) + HOLD(1). Each extra memory wait cycle adds 1.
- `data_ok` is legal no earlier than the cycle after `addr_ok`. `data_ok` in DATA is captured on that same edge.
- At most one outstanding request. ADDR is never entered while a response is owed.
- `redirect` is sampled every cycle. It never produces an `inst_req` pulse carrying the pre-redirect address in the redirect cycle.
- `pc` changes only on edges where `fetch_stall`=0, so `inst_addr` is stable throughout ADDR except after a redirect.
- Simultaneous `redirect` & `pipe_stall` in HOLD: redirect wins, the instruction is dropped, → ADDR.

## Structure
- Shared package `if_pkg` holds:
  - `fetch_state_e` enum (IDLE, ADDR, DATA, DISCARD, HOLD);
  - `RESET_VECTOR` (32'hbfc00000), used by `pc` and by benches.
- Single module, no sub-modules. Next-state logic is one `always_comb`; state and the `inst_q`/`pc_q` registers are one `always_ff`.

## Test plan
- **Reset release, zero-wait memory** (`addr_ok` same cycle, `data_ok` next): `inst_req` at 0xbfc00000 in the first post-reset cycle. `if_valid` with `if_pc`=0xbfc00000 two cycles later. `fetch_stall` drops for one cycle, then `inst_addr`=0xbfc00004.
- **Memory stretch**: `addr_ok` delayed 2 cycles, `data_ok` delayed 3 cycles. `inst_req` held 3 cycles at a constant address, `fetch_stall`=1 throughout, single capture of `inst_rdata`=0x24020001.
- **Decode backpressure**: `pipe_stall`=1 for 4 cycles while in HOLD. `if_valid`/`if_inst` stable for 4 cycles and `fetch_stall`=1. Released on the 5th cycle.
- **Redirect in DATA before `data_ok`**, target 0xbfc00100: one DISCARD response dropped, `if_valid` never asserted for the stale word, next `inst_addr`=0xbfc00100.
- **Redirect coincident with `data_ok`, and redirect during ADDR without `addr_ok`**: no capture; in the ADDR case `inst_req`=0 in that cycle. The following request uses the target address.
- **`rst`=0 asserted while in DATA**: next cycle IDLE, `inst_req`=0, `if_valid`=0. A late `data_ok` is ignored.
